pio_in_debounce_irq: RTL and testbench

- Parametrised multi-channel input PIO with an Avalon-MM slave, for push-buttons, switches and limit sensors on the HPS–FPGA bridge.
- Each channel passes through a 2-flop synchroniser, then a per-channel debounce filter.
- Each channel has runtime-selectable rising and/or falling edge capture, a per-bit IRQ mask and write-1-to-clear capture bits.
- Generalises the existing 1-bit falling-edge key PIO. This block adds width, debounce, edge-mode select and per-bit clear.

---
 rtl/pio_in_debounce_irq.sv | 126 ++++++++++++
 tb/tb_pio_in_debounce_irq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_in_debounce_irq.sv
// Multi-channel input PIO: 2-flop synchroniser, per-channel debounce, selectable
// rising/falling edge capture with write-1-to-clear bits and a masked level IRQ.
module pio_in_debounce_irq #(
    parameter int                 WIDTH     = 4,
    parameter int                 DEB_W     = 20,
    parameter int unsigned        DEB_RESET = 50000,
    parameter logic [WIDTH-1:0]   IDLE_VAL  = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int CW = DEB_W + 1;
    localparam logic [DEB_W-1:0] LIMIT_RST = DEB_W'(DEB_RESET);

    logic [WIDTH-1:0] s1_q, s1_d, s2_q, s2_d;
    logic [WIDTH-1:0] deb_q, deb_d, deb_dly_q, deb_dly_d;
    logic [WIDTH-1:0] mask_q, mask_d, cap_q, cap_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [DEB_W-1:0] limit_q, limit_d, eff_limit;
    logic [DEB_W-1:0] cnt_q [WIDTH];
    logic [DEB_W-1:0] cnt_d [WIDTH];
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] set, clr;
    logic             wr_en;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        s1_d      = in_port;
        s2_d      = s1_q;
        deb_d     = deb_q;
        deb_dly_d = deb_q;
        eff_limit = (limit_q == '0) ? DEB_W'(1) : limit_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (CW'(cnt_q[i]) + CW'(1) >= CW'(eff_limit)) begin
                // >= rather than == so lowering the limit mid-count never strands a channel
                deb_d[i] = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + DEB_W'(1);
            end
        end
    end

    always_comb begin
        limit_d   = limit_q;
        mask_d    = mask_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr       = '0;
        if (wr_en) begin
            case (address)
                3'd1:    limit_d   = writedata[DEB_W-1:0];
                3'd2:    mask_d    = writedata[WIDTH-1:0];
                3'd3:    clr       = writedata[WIDTH-1:0];
                3'd4:    rise_en_d = writedata[WIDTH-1:0];
                3'd5:    fall_en_d = writedata[WIDTH-1:0];
                default: ;
            endcase
        end
        // set is OR-ed after the clear so a same-cycle event is never lost
        set   = (deb_q & ~deb_dly_q & rise_en_q) | (~deb_q & deb_dly_q & fall_en_q);
        cap_d = (cap_q & ~clr) | set;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            3'd0:    readdata_d[WIDTH-1:0] = deb_q;
            3'd1:    readdata_d[DEB_W-1:0] = limit_q;
            3'd2:    readdata_d[WIDTH-1:0] = mask_q;
            3'd3:    readdata_d[WIDTH-1:0] = cap_q;
            3'd4:    readdata_d[WIDTH-1:0] = rise_en_q;
            3'd5:    readdata_d[WIDTH-1:0] = fall_en_q;
            default: ;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q       <= IDLE_VAL;
            s2_q       <= IDLE_VAL;
            deb_q      <= IDLE_VAL;
            deb_dly_q  <= IDLE_VAL;
            limit_q    <= LIMIT_RST;
            mask_q     <= '0;
            cap_q      <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '1;
            readdata_q <= '0;
            // NOTE: the counter array is a bank of flops, not RAM, so it is reset like any other state.
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            deb_q      <= deb_d;
            deb_dly_q  <= deb_dly_d;
            limit_q    <= limit_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            readdata_q <= readdata_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_pio_in_debounce_irq.sv
// Scoreboard bench: a reference model predicts readdata/irq per cycle, a monitor compares.
module tb_pio_in_debounce_irq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [3:0]  in_port = '0;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;

    pio_in_debounce_irq #(
        .WIDTH(4), .DEB_W(20), .DEB_RESET(50000), .IDLE_VAL(4'h0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [3:0]  m_s1, m_s2, m_q, m_qd, m_mask, m_cap, m_rise, m_fall;
    logic [19:0] m_limit;
    int          m_cnt [4];

    typedef struct {
        logic [31:0] rd;
        logic        irq;
        logic [2:0]  addr;
    } exp_t;
    exp_t sb[$];

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return {28'd0, m_q};
            3'd1:    return {12'd0, m_limit};
            3'd2:    return {28'd0, m_mask};
            3'd3:    return {28'd0, m_cap};
            3'd4:    return {28'd0, m_rise};
            3'd5:    return {28'd0, m_fall};
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_s1 = 0; m_s2 = 0; m_q = 0; m_qd = 0;
        m_mask = 0; m_cap = 0; m_rise = 0; m_fall = 4'hF;
        m_limit = 20'd50000;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic m_step();
        exp_t       e;
        logic [3:0] q_n, set_v, clr_v;
        int         lim;
        bit         wr;
        e.rd   = m_read(address);
        e.addr = address;
        wr     = chipselect && !write_n;
        lim    = (m_limit == 0) ? 1 : int'(m_limit);
        q_n    = m_q;
        for (int i = 0; i < 4; i++) begin
            if (m_s2[i] == m_q[i]) m_cnt[i] = 0;
            else if (m_cnt[i] + 1 >= lim) begin q_n[i] = m_s2[i]; m_cnt[i] = 0; end
            else m_cnt[i] = m_cnt[i] + 1;
        end
        set_v = (m_q & ~m_qd & m_rise) | (~m_q & m_qd & m_fall);
        clr_v = (wr && address == 3'd3) ? writedata[3:0] : 4'h0;
        m_cap = (m_cap & ~clr_v) | set_v;
        m_qd  = m_q;
        m_q   = q_n;
        m_s2  = m_s1;
        m_s1  = in_port;
        if (wr) begin
            case (address)
                3'd1: m_limit = writedata[19:0];
                3'd2: m_mask  = writedata[3:0];
                3'd4: m_rise  = writedata[3:0];
                3'd5: m_fall  = writedata[3:0];
                default: ;
            endcase
        end
        e.irq = |(m_cap & m_mask);
        sb.push_back(e);
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_reset();
                sb.delete();
            end else begin
                m_step();
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("readdata_addr%0d", e.addr), readdata, e.rd);
                check("irq", {31'd0, irq}, {31'd0, e.irq});
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input logic [2:0] a);
        address    = a;
        chipselect = 1'($urandom_range(0, 1));
        write_n    = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [2:0] a);
        repeat (n) cyc(a);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = $urandom;
    endtask

    task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string name);
        cyc(a);
        check(name, readdata, exp);
    endtask

    logic [31:0] rst_vals [8] = '{32'd0, 32'd50000, 32'd0, 32'd0, 32'd0, 32'hF, 32'd0, 32'd0};

    initial begin
        logic [2:0]  ra;
        logic [31:0] rd_v;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check("irq_after_reset", {31'd0, irq}, 32'd0);
        for (int a = 0; a < 8; a++) rd_chk(3'(a), rst_vals[a], $sformatf("reset_addr%0d", a));

        // Debounce: 3-cycle glitch rejected, 4-cycle pulse accepted with exact latency
        wr(3'd1, 32'd4);
        wr(3'd2, 32'd1);
        in_port = 4'b0001; idle(3, 3'd0);
        in_port = 4'b0000; idle(10, 3'd0);
        rd_chk(3'd0, 32'd0, "glitch_q");
        rd_chk(3'd3, 32'd0, "glitch_cap");
        check("glitch_irq", {31'd0, irq}, 32'd0);
        in_port = 4'b0001; idle(4, 3'd0);
        in_port = 4'b0000; cyc(3'd0); cyc(3'd0);
        check("q_before_limit", readdata, 32'd0);
        cyc(3'd0);
        check("q_at_limit", readdata, 32'd1);
        idle(12, 3'd3);
        rd_chk(3'd3, 32'd1, "fall_capture");
        check("fall_irq", {31'd0, irq}, 32'd1);

        // Rise-only mode on bit 1
        wr(3'd1, 32'd1); wr(3'd4, 32'd2); wr(3'd5, 32'd0); wr(3'd3, 32'hF);
        rd_chk(3'd3, 32'd0, "cap_cleared");
        in_port = 4'b0010; idle(6, 3'd3);
        rd_chk(3'd3, 32'd2, "rise_capture");
        in_port = 4'b0000; idle(6, 3'd3);
        rd_chk(3'd3, 32'd2, "fall_disabled");
        check("irq_masked", {31'd0, irq}, 32'd0);
        wr(3'd2, 32'd2);
        check("irq_unmasked", {31'd0, irq}, 32'd1);

        // W1C per bit, and set wins over a same-cycle clear
        wr(3'd4, 32'd3);
        in_port = 4'b0001; idle(6, 3'd3);
        rd_chk(3'd3, 32'd3, "cap_both");
        wr(3'd3, 32'd1);
        rd_chk(3'd3, 32'd2, "w1c_bit0");
        check("irq_bit1_held", {31'd0, irq}, 32'd1);
        wr(3'd3, 32'd2);
        rd_chk(3'd3, 32'd0, "w1c_bit1");
        in_port = 4'b0011; cyc(3'd3); cyc(3'd3); cyc(3'd3);
        wr(3'd3, 32'd2);
        rd_chk(3'd3, 32'd2, "set_wins");

        // Lowering the limit mid-count takes effect without a stall
        wr(3'd1, 32'd1000);
        in_port = 4'b0111; idle(600, 3'd0);
        wr(3'd1, 32'd10);
        cyc(3'd0);
        check("limit_drop_pre", readdata, 32'd3);
        cyc(3'd0);
        check("limit_drop_post", readdata, 32'd7);

        // Randomised register traffic and input activity
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                ra = 3'($urandom_range(0, 7));
                rd_v = (ra == 3'd1) ? 32'($urandom_range(0, 5)) : $urandom;
                wr(ra, rd_v);
            end else if (r == 1) begin
                address = 3'($urandom_range(0, 7)); chipselect = 1'b0; write_n = 1'b0;
                writedata = $urandom;
                @(negedge clk);
                write_n = 1'b1;
            end else begin
                if ($urandom_range(0, 3) == 0) in_port = 4'($urandom);
                cyc(3'($urandom_range(0, 7)));
            end
        end

        // Asynchronous reset mid-operation
        wr(3'd1, 32'd1); wr(3'd4, 32'hF); wr(3'd5, 32'hF); wr(3'd2, 32'hF);
        in_port = 4'b0000; idle(6, 3'd0);
        wr(3'd3, 32'hF);
        in_port = 4'b1111; idle(6, 3'd3);
        rd_chk(3'd3, 32'hF, "pre_reset_cap");
        check("pre_reset_irq", {31'd0, irq}, 32'd1);
        #2;
        reset_n = 1'b0;
        in_port = 4'b0000;
        #1;
        check("async_reset_readdata", readdata, 32'd0);
        check("async_reset_irq", {31'd0, irq}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        idle(10, 3'd3);
        rd_chk(3'd3, 32'd0, "no_cap_after_reset");
        check("no_irq_after_reset", {31'd0, irq}, 32'd0);
        rd_chk(3'd5, 32'hF, "fall_en_after_reset");
        idle(3, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
